// File: rtl/pixel_feeder.sv
// ----------------------------------------------------------------------------
// pixel_feeder
//   Source end of the upscaler pixel stream. Reads an IMG_W x IMG_H RGB888
//   frame from a synchronous frame memory (1-cycle read latency) and presents
//   each pixel on pixel_out with pixel_valid held for REPEAT consecutive
//   cycles, one cycle per horizontal phase. LINE_GAP idle cycles follow every
//   line. Within a line the next pixel is prefetched so that pixels follow
//   each other without a bubble.
//
//   Optional feature: define PIXEL_FEEDER_ABORT_EN to add the abort input,
//   which returns the FSM to IDLE from any active state without a done pulse.
//
// Ports
//   clk          in   1       clock
//   rst_n        in   1       asynchronous reset, active low
//   start        in   1       frame start request, sampled only in IDLE
//   abort        in   1       (PIXEL_FEEDER_ABORT_EN only) cancel current frame
//   mem_rd       out  1       memory read strobe
//   mem_addr     out  ADDR_W  row-major read address
//   mem_rdata    in   24      read data, valid the cycle after mem_rd
//   pixel_out    out  24      {R,G,B} pixel to upscaler
//   pixel_valid  out  1       pixel_out valid
//   sol          out  1       valid pixel is x==0
//   eol          out  1       valid pixel is x==IMG_W-1
//   busy         out  1       frame in progress (FETCH through DONE)
//   done         out  1       one-cycle pulse after the final valid cycle
// ----------------------------------------------------------------------------
module pixel_feeder #(
    parameter int IMG_W    = 384,
    parameter int IMG_H    = 216,
    parameter int REPEAT   = 3,
    parameter int LINE_GAP = 2,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef PIXEL_FEEDER_ABORT_EN
    input  logic              abort,
`endif
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_rdata,
    output logic [23:0]       pixel_out,
    output logic              pixel_valid,
    output logic              sol,
    output logic              eol,
    output logic              busy,
    output logic              done
);

    localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int RMAX = (REPEAT > LINE_GAP) ? REPEAT : LINE_GAP;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
    localparam logic [RW-1:0] REP_PRE  = RW'(REPEAT - 2);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT - 1);
    localparam logic [RW-1:0] GAP_LAST = RW'(LINE_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_STREAM,
        S_GAP,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [XW-1:0]       r_x;
    logic [YW-1:0]       r_y;
    // Shared between phase counting in STREAM and idle counting in GAP.
    logic [RW-1:0]       r_rep;
    logic [ADDR_W-1:0]   r_addr;
    logic [23:0]         r_pixel;

    logic                w_abort;
    logic                w_prefetch;
    logic                w_x_last;
    logic                w_y_last;
    logic                w_rep_last;

`ifdef PIXEL_FEEDER_ABORT_EN
    assign w_abort = abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_x_last   = (r_x == X_LAST);
    assign w_y_last   = (r_y == Y_LAST);
    assign w_rep_last = (r_rep == REP_LAST);

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        w_next      = r_state;
        mem_rd      = 1'b0;
        w_prefetch  = 1'b0;
        pixel_valid = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                busy   = 1'b1;
                mem_rd = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                busy   = 1'b1;
                w_next = S_STREAM;
            end
            S_STREAM: begin
                busy        = 1'b1;
                pixel_valid = 1'b1;
                // Read the next pixel one phase early so its data lands
                // exactly when the current pixel's last phase ends.
                if ((r_rep == REP_PRE) && !w_x_last) begin
                    mem_rd     = 1'b1;
                    w_prefetch = 1'b1;
                end
                if (w_rep_last && w_x_last) begin
                    w_next = w_y_last ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                busy = 1'b1;
                if (r_rep == GAP_LAST) w_next = S_FETCH;
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Abort wins over every transition and silences the cycle it arrives in.
        if (w_abort) begin
            w_next      = S_IDLE;
            mem_rd      = 1'b0;
            w_prefetch  = 1'b0;
            pixel_valid = 1'b0;
            busy        = 1'b0;
            done        = 1'b0;
        end
    end

    assign mem_addr  = r_addr + ADDR_W'(w_prefetch);
    assign pixel_out = r_pixel;
    assign sol       = pixel_valid && (r_x == '0);
    assign eol       = pixel_valid && w_x_last;

    // ---------------- Counters and pixel register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_rep   <= '0;
            r_addr  <= '0;
            r_pixel <= '0;
        end else if (!w_abort) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x    <= '0;
                        r_y    <= '0;
                        r_rep  <= '0;
                        r_addr <= '0;
                    end
                end
                S_WAIT: begin
                    r_pixel <= mem_rdata;
                    r_rep   <= '0;
                end
                S_STREAM: begin
                    if (w_rep_last) begin
                        // rep returns to 0 so GAP starts counting from zero.
                        r_rep <= '0;
                        if (!w_x_last) begin
                            r_pixel <= mem_rdata;
                            r_x     <= r_x + XW'(1);
                            r_addr  <= r_addr + ADDR_W'(1);
                        end else if (!w_y_last) begin
                            r_x    <= '0;
                            r_y    <= r_y + YW'(1);
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end else begin
                        r_rep <= r_rep + RW'(1);
                    end
                end
                S_GAP: begin
                    r_rep <= r_rep + RW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_feeder.sv
// ----------------------------------------------------------------------------
// tb_pixel_feeder
//   Directed bench for pixel_feeder with IMG_W=4, IMG_H=2, REPEAT=3,
//   LINE_GAP=2 and a frame memory holding mem[a] = 24'h100000 + a.
//   A frame trace is 32 sampled cycles starting with the cycle after the edge
//   that accepts start:
//     0 FETCH(addr 0), 1 WAIT, 2..13 line 0 pixels (3 cycles each),
//     14..15 GAP, 16 FETCH(addr 4), 17 WAIT, 18..29 line 1 pixels,
//     30 DONE, 31 IDLE.
// ----------------------------------------------------------------------------
module tb_pixel_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
`ifdef PIXEL_FEEDER_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic        mem_rd;
    logic [16:0] mem_addr;
    logic [23:0] mem_rdata = '0;
    logic [23:0] pixel_out;
    logic        pixel_valid;
    logic        sol;
    logic        eol;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pixel_feeder #(
        .IMG_W    (4),
        .IMG_H    (2),
        .REPEAT   (3),
        .LINE_GAP (2),
        .ADDR_W   (17)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
`ifdef PIXEL_FEEDER_ABORT_EN
        .abort       (abort),
`endif
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid),
        .sol         (sol),
        .eol         (eol),
        .busy        (busy),
        .done        (done)
    );

    // Synchronous frame memory, one cycle read latency.
    always_ff @(posedge clk) begin
        if (mem_rd) mem_rdata <= 24'h100000 + 24'(mem_addr);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Packed expectation: {busy,done,valid,sol,eol,rd,addr[3:0],pixel[23:0]}
    function automatic logic [63:0] exp_at(input int i);
        logic [63:0] e;
        int line, j, base, p, r, pp, addr, pix;
        bit rd, vld, s, l;
        e    = '0;
        line = (i >= 16) ? 1 : 0;
        j    = i - 16 * line;
        base = 4 * line;
        rd = 0; vld = 0; s = 0; l = 0; addr = 0;
        if (j == 0) begin
            rd   = 1;
            addr = base;
        end
        if (j >= 2 && j < 14) begin
            p   = (j - 2) / 3;
            r   = (j - 2) % 3;
            vld = 1;
            s   = (p == 0);
            l   = (p == 3);
            if (r == 1 && p != 3) begin
                rd   = 1;
                addr = base + p + 1;
            end
        end
        if (i < 2) pix = 0;
        else if (j < 2) pix = 'h100003;
        else begin
            pp  = (j - 2) / 3;
            if (pp > 3) pp = 3;
            pix = 'h100000 + base + pp;
        end
        e[33]    = (i <= 30);
        e[32]    = (i == 30);
        e[31]    = vld;
        e[30]    = s;
        e[29]    = l;
        e[28]    = rd;
        e[27:24] = 4'(addr);
        e[23:0]  = 24'(pix);
        return e;
    endfunction

    // Call at a negedge. Start pulses at ign_a/ign_b land while busy; chain
    // raises start in the IDLE cycle after DONE to launch the next frame.
    task automatic run_frame(input string tag, input bit do_start, input int ign_a,
                             input int ign_b, input bit chain);
        logic [63:0] act;
        int nv, nrd, nd;
        nv = 0; nrd = 0; nd = 0;
        if (do_start) start = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            act = '0;
            act[33]    = busy;
            act[32]    = done;
            act[31]    = pixel_valid;
            act[30]    = sol;
            act[29]    = eol;
            act[28]    = mem_rd;
            act[27:24] = mem_rd ? mem_addr[3:0] : 4'h0;
            act[23:0]  = (i >= 2) ? pixel_out : 24'h0;
            check($sformatf("%s_c%0d", tag, i), act, exp_at(i));
            if (pixel_valid) nv++;
            if (mem_rd) nrd++;
            if (done) nd++;
            start = (i == ign_a) || (i == ign_b) || (chain && i == 31);
        end
        check({tag, "_nvalid"}, 64'(nv), 64'd24);
        check({tag, "_nrd"}, 64'(nrd), 64'd8);
        check({tag, "_ndone"}, 64'(nd), 64'd1);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_valid", 64'(pixel_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd", 64'(mem_rd), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_pix", 64'(pixel_out), 64'd0);
        check("rst_soleol", 64'({sol, eol}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame
        run_frame("basic", 1'b1, -1, -1, 1'b0);
        @(negedge clk);

        // Start pulses mid-line and during DONE are ignored; the start in the
        // cycle after DONE launches a second identical frame.
        run_frame("ign", 1'b1, 7, 30, 1'b1);
        run_frame("chain", 1'b0, -1, -1, 1'b0);
        @(negedge clk);

        // Asynchronous reset during pixel 100002
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
        end
        check("mid_pix", 64'({pixel_valid, pixel_out}), {39'd0, 1'b1, 24'h100002});
        #2 rst_n = 1'b0;
        #1;
        check("async_out", 64'({pixel_valid, busy, done, mem_rd, sol, eol, pixel_out}), 64'd0);
        @(negedge clk);
        check("async_hold", 64'({pixel_valid, busy, pixel_out}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("after_rst", 1'b1, -1, -1, 1'b0);
        @(negedge clk);

`ifdef PIXEL_FEEDER_ABORT_EN
        // Abort while in the line gap
        begin
            int nv, nd;
            nv = 0; nd = 0;
            start = 1'b1;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (i == 0) start = 1'b0;
            end
            check("ab_in_gap", 64'({busy, pixel_valid}), 64'b10);
            abort = 1'b1;
            #1;
            check("ab_same_cyc", 64'({busy, mem_rd, pixel_valid}), 64'd0);
            @(negedge clk);
            abort = 1'b0;
            check("ab_busy", 64'(busy), 64'd0);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (pixel_valid) nv++;
                if (done) nd++;
            end
            check("ab_nvalid", 64'(nv), 64'd0);
            check("ab_ndone", 64'(nd), 64'd0);
            run_frame("ab_replay", 1'b1, -1, -1, 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
